// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - state encoding and default geometry for the conv window scheduler
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  localparam int DEF_IMG_W  = 20;
  localparam int DEF_IMG_H  = 20;
  localparam int DEF_K      = 5;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 16;

  localparam int PIX_NUM = DEF_IMG_W * DEF_IMG_H;
  localparam int OUT_W   = DEF_IMG_W - DEF_K + 1;
  localparam int OUT_H   = DEF_IMG_H - DEF_K + 1;

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - r/c/kc window counters and K parallel read addresses
module conv_addr_gen
  import conv_sched_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  adv_i,
  output logic [K*ADDR_W-1:0]   rd_addr_o,
  output logic                  col_last_o,
  output logic                  last_o
);

  localparam logic [ADDR_W-1:0] KC_MAX   = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] C_MAX    = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] R_MAX    = ADDR_W'(IMG_H - K);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  logic [ADDR_W-1:0] kc_q, kc_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic              col_last_q, col_last_d;
  logic              last_q, last_d;

  // Row base tracks r*IMG_W by accumulation so no runtime multiplier is needed.
  always_comb begin
    kc_d = kc_q;
    c_d  = c_q;
    r_d  = r_q;
    rb_d = rb_q;
    if (clear_i) begin
      kc_d = '0;
      c_d  = '0;
      r_d  = '0;
      rb_d = '0;
    end else if (adv_i) begin
      if (kc_q == KC_MAX) begin
        kc_d = '0;
        if (c_q == C_MAX) begin
          c_d = '0;
          if (r_q == R_MAX) begin
            r_d  = '0;
            rb_d = '0;
          end else begin
            r_d  = r_q + ONE;
            rb_d = rb_q + ROW_STEP;
          end
        end else begin
          c_d = c_q + ONE;
        end
      end else begin
        kc_d = kc_q + ONE;
      end
    end
    col_last_d = (kc_d == KC_MAX);
    last_d     = col_last_d && (c_d == C_MAX) && (r_d == R_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      kc_q       <= '0;
      c_q        <= '0;
      r_q        <= '0;
      rb_q       <= '0;
      col_last_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      kc_q       <= kc_d;
      c_q        <= c_d;
      r_q        <= r_d;
      rb_q       <= rb_d;
      col_last_q <= col_last_d;
      last_q     <= last_d;
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_slice
    localparam logic [ADDR_W-1:0] OFF = ADDR_W'(i * IMG_W);
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] a_d;

    assign a_d = rb_d + OFF + c_d + kc_d;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) a_q <= '0;
      else          a_q <= a_d;
    end

    assign rd_addr_o[i*ADDR_W +: ADDR_W] = a_q;
  end

  assign col_last_o = col_last_q;
  assign last_o     = last_q;

endmodule

// File: rtl/conv_window_sched.sv
// rtl/conv_window_sched.sv - feature-map load then K-row window scan for the MAC array
module conv_window_sched
  import conv_sched_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ld_valid,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  ld_ready,
  output logic                  buf_we,
  output logic [ADDR_W-1:0]     buf_wr_addr,
  output logic [DATA_W-1:0]     buf_din,
  output logic [K*ADDR_W-1:0]   buf_rd_addr,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  win_col_last,
  output logic                  win_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  sched_state_e      state_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic              ld_ready_q;
  logic              win_valid_q;
  logic              busy_q;
  logic              done_q;

  logic ld_fire;
  logic ld_final;
  logic beat_fire;
  logic col_last_raw;
  logic last_raw;

  assign ld_fire   = ld_valid && ld_ready_q;
  assign ld_final  = ld_fire && (wr_cnt_q == PIX_LAST);
  assign beat_fire = win_valid_q && win_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      ld_ready_q  <= 1'b0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            wr_cnt_q   <= '0;
          end
        end
        LOAD: begin
          if (ld_final) begin
            state_q     <= SCAN;
            ld_ready_q  <= 1'b0;
            win_valid_q <= 1'b1;
            wr_cnt_q    <= '0;
          end else if (ld_fire) begin
            wr_cnt_q <= wr_cnt_q + ONE;
          end
        end
        SCAN: begin
          if (beat_fire && last_raw) begin
            state_q     <= DONE;
            win_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The last load word clears the generator so the first window is ready as SCAN begins.
  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clear_i    (ld_final),
    .adv_i      (beat_fire),
    .rd_addr_o  (buf_rd_addr),
    .col_last_o (col_last_raw),
    .last_o     (last_raw)
  );

  assign ld_ready     = ld_ready_q;
  assign buf_we       = ld_fire;
  assign buf_wr_addr  = ld_fire ? wr_cnt_q : '0;
  assign buf_din      = ld_fire ? ld_data : '0;
  assign win_valid    = win_valid_q;
  assign win_col_last = win_valid_q && col_last_raw;
  assign win_last     = win_valid_q && last_raw;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// tb/tb_conv_window_sched.sv - scoreboard bench for conv_window_sched (default and 6x6 K=3)
module tb_conv_window_sched;

  typedef struct {
    logic [12:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [90:0] addr;
    logic        cl;
    logic        lst;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_b, ld_valid, ld_valid_b, win_ready, win_ready_b;
  logic [15:0] ld_data, ld_data_b;

  logic        ld_ready_a, buf_we_a, win_valid_a, win_col_last_a, win_last_a, busy_a, done_a;
  logic [12:0] buf_wr_addr_a;
  logic [15:0] buf_din_a;
  logic [64:0] rd_a;
  logic        ld_ready_b, buf_we_b, win_valid_b, win_col_last_b, win_last_b, busy_b, done_b;
  logic [12:0] buf_wr_addr_b;
  logic [15:0] buf_din_b;
  logic [38:0] rd_b;

  int errors = 0;
  int checks = 0;
  int beat_a = 0, beat_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  bit done_chk_a = 0, done_chk_b = 0;
  wr_t   wq_a[$], wq_b[$];
  beat_t exp_a[$], exp_b[$];

  always #5 clk = ~clk;

  conv_window_sched dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_a), .buf_we(buf_we_a), .buf_wr_addr(buf_wr_addr_a), .buf_din(buf_din_a),
    .buf_rd_addr(rd_a), .win_valid(win_valid_a), .win_ready(win_ready),
    .win_col_last(win_col_last_a), .win_last(win_last_a), .busy(busy_a), .done(done_a)
  );

  conv_window_sched #(.IMG_W(6), .IMG_H(6), .K(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ld_valid(ld_valid_b), .ld_data(ld_data_b),
    .ld_ready(ld_ready_b), .buf_we(buf_we_b), .buf_wr_addr(buf_wr_addr_b), .buf_din(buf_din_b),
    .buf_rd_addr(rd_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
    .win_col_last(win_col_last_b), .win_last(win_last_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string nm, input logic [90:0] act, input logic [90:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_scan(input bit use_b, input int w, input int h, input int k);
    beat_t e;
    for (int r = 0; r <= h - k; r++)
      for (int c = 0; c <= w - k; c++)
        for (int kc = 0; kc < k; kc++) begin
          e.addr = '0;
          for (int i = 0; i < k; i++) e.addr[i*13 +: 13] = 13'((r + i) * w + c + kc);
          e.cl  = (kc == k - 1);
          e.lst = (r == h - k) && (c == w - k) && (kc == k - 1);
          if (use_b) exp_b.push_back(e); else exp_a.push_back(e);
        end
  endtask

  always @(negedge clk) begin
    wr_t w;
    beat_t e;
    if (rst_n) begin
      if (done_chk_a) begin
        chk("a_done_after_last", done_a, 1);
        chk("a_valid_drop", win_valid_a, 0);
        done_chk_a = 0;
      end
      if (done_a) done_cnt_a++;
      if (buf_we_a) begin
        if (wq_a.size() == 0) chk("a_unexpected_write", buf_we_a, 0);
        else begin
          w = wq_a.pop_front();
          chk("a_wr_addr", buf_wr_addr_a, w.a);
          chk("a_wr_data", buf_din_a, w.d);
        end
      end
      if (win_valid_a) begin
        if (exp_a.size() == 0) chk("a_unexpected_beat", win_valid_a, 0);
        else begin
          e = exp_a[0];
          chk("a_rd_addr", 91'(rd_a), e.addr);
          chk("a_col_last", win_col_last_a, e.cl);
          chk("a_win_last", win_last_a, e.lst);
          if (win_ready) begin
            if (beat_a == 0)    chk("a_first_beat", rd_a, {13'd80, 13'd60, 13'd40, 13'd20, 13'd0});
            if (beat_a == 5)    chk("a_sixth_beat", rd_a, {13'd81, 13'd61, 13'd41, 13'd21, 13'd1});
            if (beat_a == 1279) chk("a_last_beat", {win_last_a, rd_a},
                                    {1'b1, 13'd399, 13'd379, 13'd359, 13'd339, 13'd319});
            void'(exp_a.pop_front());
            beat_a++;
            if (e.lst) done_chk_a = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    wr_t w;
    beat_t e;
    if (rst_n) begin
      if (done_chk_b) begin
        chk("b_done_after_last", done_b, 1);
        chk("b_valid_drop", win_valid_b, 0);
        done_chk_b = 0;
      end
      if (done_b) done_cnt_b++;
      if (buf_we_b) begin
        if (wq_b.size() == 0) chk("b_unexpected_write", buf_we_b, 0);
        else begin
          w = wq_b.pop_front();
          chk("b_wr_addr", buf_wr_addr_b, w.a);
          chk("b_wr_data", buf_din_b, w.d);
        end
      end
      if (win_valid_b) begin
        if (exp_b.size() == 0) chk("b_unexpected_beat", win_valid_b, 0);
        else begin
          e = exp_b[0];
          chk("b_rd_addr", 91'(rd_b), e.addr);
          chk("b_col_last", win_col_last_b, e.cl);
          chk("b_win_last", win_last_b, e.lst);
          if (win_ready_b) begin
            if (beat_b == 47) chk("b_last_beat", {win_last_b, rd_b}, {1'b1, 13'd35, 13'd29, 13'd23});
            void'(exp_b.pop_front());
            beat_b++;
            if (e.lst) done_chk_b = 1;
          end
        end
      end
    end
  end

  task automatic load_words(input bit use_b, input int n, input bit stall);
    int g;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.a = 13'(i);
      w.d = 16'(i) ^ 16'h5A00;
      if (use_b) begin
        wq_b.push_back(w);
        ld_valid_b = 1;
        ld_data_b  = w.d;
      end else begin
        wq_a.push_back(w);
        ld_valid = 1;
        ld_data  = w.d;
        if (i == 10) start = 1;
      end
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!(use_b ? ld_ready_b : ld_ready_a) && g < 20);
      if (g >= 20) chk("ld_ready_timeout", use_b ? ld_ready_b : ld_ready_a, 1);
      @(posedge clk); #1;
      start = 0;
      if (stall) begin
        ld_valid   = 0;
        ld_valid_b = 0;
        @(posedge clk); #1;
      end
    end
    ld_valid   = 0;
    ld_valid_b = 0;
  endtask

  task automatic run_a(input bit stall, input bit bp, input int rst_at);
    int d0, g;
    beat_a = 0;
    d0 = done_cnt_a;
    push_scan(0, 20, 20, 5);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("a_busy_load", {busy_a, ld_ready_a}, 2'b11);
    @(posedge clk); #1;
    load_words(0, 400, stall);
    g = 0;
    while (busy_a && g < 5000) begin
      @(posedge clk); #1;
      g++;
      start = (g == 3);
      if (bp && beat_a == 6) begin
        win_ready = 0;
        repeat (3) begin
          @(negedge clk);
          chk("a_bp_hold", {win_valid_a, rd_a}, {1'b1, 13'd82, 13'd62, 13'd42, 13'd22, 13'd2});
          @(posedge clk); #1;
        end
        win_ready = 1;
      end
      if (rst_at >= 0 && beat_a == rst_at) begin
        rst_n = 0;
        exp_a.delete();
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("a_rst_state", {busy_a, win_valid_a, ld_ready_a, rd_a}, '0);
        repeat (20) @(posedge clk);
        #1;
        chk("a_rst_no_done", done_cnt_a - d0, 0);
        return;
      end
    end
    start = 0;
    chk("a_scan_timeout", busy_a, 0);
    chk("a_beats", beat_a, 1280);
    chk("a_done_count", done_cnt_a - d0, 1);
    chk("a_queues_empty", exp_a.size() + wq_a.size(), 0);
  endtask

  initial begin
    int g;
    rst_n = 0; start = 0; start_b = 0; ld_valid = 0; ld_valid_b = 0;
    ld_data = '0; ld_data_b = '0; win_ready = 1; win_ready_b = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("a_reset", {busy_a, done_a, win_valid_a, ld_ready_a, buf_we_a, win_last_a, rd_a}, '0);
    chk("b_reset", {busy_b, done_b, win_valid_b, ld_ready_b, buf_we_b, rd_b}, '0);

    @(posedge clk); #1;
    ld_valid = 1; ld_data = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("a_idle_ld_valid", {buf_we_a, ld_ready_a, busy_a}, 3'b000);
    end
    @(posedge clk); #1;
    ld_valid = 0;

    run_a(0, 0, -1);
    run_a(1, 1, -1);
    run_a(0, 0, 500);
    run_a(0, 0, -1);

    beat_b = 0;
    push_scan(1, 6, 6, 3);
    start_b = 1;
    @(posedge clk); #1;
    start_b = 0;
    load_words(1, 36, 0);
    g = 0;
    while (busy_b && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    chk("b_scan_timeout", busy_b, 0);
    chk("b_beats", beat_b, 48);
    chk("b_done_count", done_cnt_b, 1);
    chk("b_queues_empty", exp_b.size() + wq_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
